wvb_overflow_ctrl_mc: RTL

//  Multi-channel waveform-buffer overflow controller, one instance per waveform-buffer group.

---
 rtl/wvb_overflow_ctrl_mc.sv | 100 ++++++++++
 1 files changed

// File: rtl/wvb_overflow_ctrl_mc.sv
// Multi-channel waveform-buffer overflow controller: words-used tracking, hysteresis overflow, flags.
// Define WVB_OVFL_CNT_EN to build the per-channel saturating overflow-episode counters.
module wvb_overflow_ctrl_mc #(
   parameter int P_N_CHAN    = 4,
   parameter int P_ADR_WIDTH = 12,
   parameter int P_CNT_WIDTH = 16
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [P_N_CHAN*P_ADR_WIDTH-1:0]    wvb_wr_addr,
   input  logic [P_N_CHAN-1:0]                wvb_rddone,
   input  logic [P_N_CHAN*P_ADR_WIDTH-1:0]    stop_addr,
   input  logic [P_N_CHAN-1:0]                hdr_full,
   input  logic [P_ADR_WIDTH:0]               resume_thresh,
   input  logic [P_ADR_WIDTH:0]               afull_thresh,
   input  logic [P_N_CHAN-1:0]                ovfl_clr,
   output logic [P_N_CHAN-1:0]                overflow,
   output logic [P_N_CHAN-1:0]                almost_full,
   output logic [P_N_CHAN-1:0]                ovfl_sticky,
   output logic [P_N_CHAN*(P_ADR_WIDTH+1)-1:0] wvb_wused,
   output logic [P_N_CHAN*P_CNT_WIDTH-1:0]    ovfl_cnt
);

   localparam logic ST_RUN  = 1'b0;
   localparam logic ST_OVFL = 1'b1;

   for (genvar c = 0; c < P_N_CHAN; c++) begin : g_chan
      logic [P_ADR_WIDTH-1:0] wr_addr;
      logic [P_ADR_WIDTH-1:0] stop;
      logic [P_ADR_WIDTH-1:0] last_rd_addr;
      logic [P_ADR_WIDTH-1:0] next_rd;
      logic [P_ADR_WIDTH-1:0] diff;
      logic [P_ADR_WIDTH:0]   wused;
      logic                   state;
      logic                   afull;
      logic                   sticky;
      logic                   full_now;
      logic                   enter_ovfl;
      logic                   leave_ovfl;

      assign wr_addr = wvb_wr_addr[c*P_ADR_WIDTH +: P_ADR_WIDTH];
      assign stop    = stop_addr[c*P_ADR_WIDTH +: P_ADR_WIDTH];
      assign next_rd = last_rd_addr + P_ADR_WIDTH'(1);
      assign diff    = wr_addr - next_rd;

      // Full compares against the pre-update read pointer, so a coincident rddone cannot mask it.
      assign full_now   = hdr_full[c] | (wr_addr == last_rd_addr);
      assign enter_ovfl = (state == ST_RUN) & full_now;
      assign leave_ovfl = (state == ST_OVFL) & ~full_now & (wused <= resume_thresh);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            last_rd_addr <= '1;
            wused        <= '0;
            state        <= ST_RUN;
            afull        <= 1'b0;
            sticky       <= 1'b0;
         end else begin
            if (wvb_rddone[c])
               last_rd_addr <= stop;
            wused <= {1'b0, diff};
            afull <= (wused >= afull_thresh);
            if (enter_ovfl)
               state <= ST_OVFL;
            else if (leave_ovfl)
               state <= ST_RUN;
            if (enter_ovfl)
               sticky <= 1'b1;
            else if (ovfl_clr[c])
               sticky <= 1'b0;
         end
      end

      assign overflow[c]    = full_now | (state == ST_OVFL);
      assign almost_full[c] = afull;
      assign ovfl_sticky[c] = sticky;
      assign wvb_wused[c*(P_ADR_WIDTH+1) +: (P_ADR_WIDTH+1)] = wused;

`ifdef WVB_OVFL_CNT_EN
      logic [P_CNT_WIDTH-1:0] cnt;

      // A clear coinciding with a new episode leaves that episode counted.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)
            cnt <= '0;
         else if (ovfl_clr[c] && enter_ovfl)
            cnt <= P_CNT_WIDTH'(1);
         else if (ovfl_clr[c])
            cnt <= '0;
         else if (enter_ovfl && (cnt != '1))
            cnt <= cnt + P_CNT_WIDTH'(1);
      end

      assign ovfl_cnt[c*P_CNT_WIDTH +: P_CNT_WIDTH] = cnt;
`else
      assign ovfl_cnt[c*P_CNT_WIDTH +: P_CNT_WIDTH] = '0;
`endif
   end

endmodule
